// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver with Set-2 make/break/extended decode
// and a small show-ahead event FIFO.
//
// Ports:
//   iCLK, iRST_n           system clock, async active-low reset
//   iPS2_CLK, iPS2_DAT     raw asynchronous PS/2 pins
//   iREAD                  pop FIFO head this cycle
//   oVALID                 FIFO non-empty
//   oDATA, oEXT, oBREAK    head entry (scan code, E0-prefixed, F0-prefixed); 0 when empty
//   oKEY_PRESSED           one-cycle pulse per accepted make code
//   oLAST_KEY              most recent make code (held)
//   oFRAME_ERR             one-cycle pulse on parity, stop or timeout error
//   oOVERFLOW              one-cycle pulse when an event is dropped on a full FIFO
module ps2_keyboard_rx #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 25000,
   parameter int unsigned FIFO_AW        = 2
) (
   input  logic       iCLK,
   input  logic       iRST_n,
   input  logic       iPS2_CLK,
   input  logic       iPS2_DAT,
   input  logic       iREAD,
   output logic       oVALID,
   output logic [7:0] oDATA,
   output logic       oEXT,
   output logic       oBREAK,
   output logic       oKEY_PRESSED,
   output logic [7:0] oLAST_KEY,
   output logic       oFRAME_ERR,
   output logic       oOVERFLOW
);

   localparam int unsigned FCNT_W  = $clog2(FILTER_LEN + 1);
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned DEPTH   = 1 << FIFO_AW;
   localparam int unsigned CNT_W   = FIFO_AW + 1;
   localparam int unsigned ENTRY_W = 10;

   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BREAK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Pin synchronisers; reset to the idle-high line level
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic                   clk_s;
   logic                   dat_s;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], iPS2_CLK};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], iPS2_DAT};
      end
   end

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign dat_s = dat_sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Glitch filter: the filtered clock follows only after FILTER_LEN
   // consecutive samples that disagree with its current value
   // ---------------------------------------------------------------------
   logic [FCNT_W-1:0] fcnt_q;
   logic              filt_q;
   logic              filt_d_q;
   logic              fall_c;
   logic              edge_c;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         fcnt_q   <= '0;
         filt_q   <= 1'b1;
         filt_d_q <= 1'b1;
      end else begin
         filt_d_q <= filt_q;
         if (clk_s != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
               filt_q <= clk_s;
               fcnt_q <= '0;
            end else begin
               fcnt_q <= fcnt_q + FCNT_W'(1);
            end
         end else begin
            fcnt_q <= '0;
         end
      end
   end

   assign fall_c = filt_d_q & ~filt_q;
   assign edge_c = filt_d_q ^ filt_q;

   // ---------------------------------------------------------------------
   // Inactivity timer; saturates so a long idle line never wraps it
   // ---------------------------------------------------------------------
   logic [TO_W-1:0] to_q;
   logic            to_hit_c;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         to_q <= '0;
      end else if (edge_c) begin
         to_q <= '0;
      end else if (to_q != TO_W'(TIMEOUT_CYCLES - 1)) begin
         to_q <= to_q + TO_W'(1);
      end
   end

   assign to_hit_c = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

   // ---------------------------------------------------------------------
   // Frame FSM: state register
   // ---------------------------------------------------------------------
   state_t     state_q, state_n;
   logic [2:0] bitcnt_q, bitcnt_n;
   logic [7:0] shift_q, shift_n;
   logic       perr_q, perr_n;
   logic       byte_ok_c;
   logic       frame_err_c;

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         bitcnt_q <= bitcnt_n;
         shift_q  <= shift_n;
         perr_q   <= perr_n;
      end
   end

   // Frame FSM: next state; byte_ok/frame_err fire in the stop-sample cycle
   always_comb begin
      state_n     = state_q;
      bitcnt_n    = bitcnt_q;
      shift_n     = shift_q;
      perr_n      = perr_q;
      byte_ok_c   = 1'b0;
      frame_err_c = 1'b0;
      if ((state_q != IDLE) && to_hit_c) begin
         state_n     = IDLE;
         frame_err_c = 1'b1;
      end else if (fall_c) begin
         unique case (state_q)
            IDLE: begin
               if (!dat_s) begin
                  state_n  = DATA;
                  bitcnt_n = '0;
               end
            end
            DATA: begin
               shift_n  = {dat_s, shift_q[7:1]};
               bitcnt_n = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_n = PARITY;
               end
            end
            PARITY: begin
               // Odd parity: an even total count of ones is an error
               perr_n  = ~(^shift_q ^ dat_s);
               state_n = STOP;
            end
            STOP: begin
               if (dat_s && !perr_q) begin
                  byte_ok_c = 1'b1;
               end else begin
                  frame_err_c = 1'b1;
               end
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Decoder and FIFO control
   // ---------------------------------------------------------------------
   logic                 ext_q;
   logic                 brk_q;
   logic [ENTRY_W-1:0]   mem_q [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_n;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_n;
   logic [CNT_W-1:0]     count_q, count_n;
   logic                 is_prefix_c;
   logic                 push_req_c;
   logic                 push_do_c;
   logic                 pop_c;
   logic                 full_c;
   logic                 ovf_c;
   logic [ENTRY_W-1:0]   entry_c;
   logic [ENTRY_W-1:0]   head_n;

   always_comb begin
      is_prefix_c = (shift_q == CODE_EXT) || (shift_q == CODE_BREAK);
      push_req_c  = byte_ok_c && !is_prefix_c;
      full_c      = (count_q == CNT_W'(DEPTH));
      pop_c       = iREAD && (count_q != '0);
      push_do_c   = push_req_c && (!full_c || pop_c);
      ovf_c       = push_req_c && full_c && !pop_c;
      entry_c     = {ext_q, brk_q, shift_q};
      wr_ptr_n    = wr_ptr_q + FIFO_AW'(push_do_c);
      rd_ptr_n    = rd_ptr_q + FIFO_AW'(pop_c);
      count_n     = count_q + CNT_W'(push_do_c) - CNT_W'(pop_c);
      // The incoming entry is the new head only when nothing else remains
      head_n      = '0;
      if (count_n != '0) begin
         if (push_do_c && (rd_ptr_n == wr_ptr_q)) begin
            head_n = entry_c;
         end else begin
            head_n = mem_q[rd_ptr_n];
         end
      end
   end

   // FIFO storage; contents need no reset since pointers qualify them
   always_ff @(posedge iCLK) begin
      if (push_do_c) begin
         mem_q[wr_ptr_q] <= entry_c;
      end
   end

   // Pointers, prefix flags and registered outputs
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         oVALID       <= 1'b0;
         oDATA        <= '0;
         oEXT         <= 1'b0;
         oBREAK       <= 1'b0;
         oKEY_PRESSED <= 1'b0;
         oLAST_KEY    <= '0;
         oFRAME_ERR   <= 1'b0;
         oOVERFLOW    <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_n;
         rd_ptr_q     <= rd_ptr_n;
         count_q      <= count_n;
         oVALID       <= (count_n != '0);
         {oEXT, oBREAK, oDATA} <= head_n;
         oKEY_PRESSED <= push_req_c && !brk_q;
         oFRAME_ERR   <= frame_err_c;
         oOVERFLOW    <= ovf_c;
         if (byte_ok_c) begin
            if (shift_q == CODE_EXT) begin
               ext_q <= 1'b1;
            end else if (shift_q == CODE_BREAK) begin
               brk_q <= 1'b1;
            end else begin
               ext_q <= 1'b0;
               brk_q <= 1'b0;
            end
         end
         if (push_req_c && !brk_q) begin
            oLAST_KEY <= shift_q;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed self-checking bench for ps2_keyboard_rx.
// PS/2 bit period is 40 system clocks; data changes mid clock-high.
module tb_ps2_keyboard_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       rd = 1'b0;
   logic       valid;
   logic [7:0] data;
   logic       ext;
   logic       brk;
   logic       key_pressed;
   logic [7:0] last_key;
   logic       frame_err;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int kp_cnt = 0;
   int ferr_cnt = 0;
   int ovf_cnt = 0;

   ps2_keyboard_rx #(
      .SYNC_STAGES(2),
      .FILTER_LEN(4),
      .TIMEOUT_CYCLES(200),
      .FIFO_AW(2)
   ) dut (
      .iCLK(clk),
      .iRST_n(rst_n),
      .iPS2_CLK(ps2_clk),
      .iPS2_DAT(ps2_dat),
      .iREAD(rd),
      .oVALID(valid),
      .oDATA(data),
      .oEXT(ext),
      .oBREAK(brk),
      .oKEY_PRESSED(key_pressed),
      .oLAST_KEY(last_key),
      .oFRAME_ERR(frame_err),
      .oOVERFLOW(overflow)
   );

   always #5 clk = ~clk;

   // Count pulse cycles of the strobe outputs
   always @(negedge clk) begin
      if (key_pressed) kp_cnt++;
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2_dat = b;
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_parity);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_parity);
      ps2_bit(1'b1);
      ps2_dat = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
   endtask

   // Start bit plus n data bits, then the clock stays high
   task automatic send_partial(input logic [7:0] b, input int n);
      ps2_bit(1'b0);
      for (int i = 0; i < n; i++) ps2_bit(b[i]);
      ps2_dat = 1'b1;
   endtask

   task automatic pop();
      @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   logic [7:0] ovf_codes [5];

   initial begin
      ovf_codes[0] = 8'h15;
      ovf_codes[1] = 8'h1D;
      ovf_codes[2] = 8'h24;
      ovf_codes[3] = 8'h2D;
      ovf_codes[4] = 8'h2C;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", 16'({valid, data, ext, brk, key_pressed, frame_err, overflow}), 16'h0);
      chk("reset_last_key", 16'(last_key), 16'h0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Plain make code 0x1C
      send_byte(8'h1C, 1'b0);
      chk("make_kp_count", 16'(kp_cnt), 16'd1);
      chk("make_last_key", 16'(last_key), 16'h1C);
      chk("make_valid", 16'(valid), 16'd1);
      chk("make_data", 16'(data), 16'h1C);
      chk("make_ext_brk", 16'({ext, brk}), 16'd0);
      pop();
      chk("make_pop_valid", 16'(valid), 16'd0);
      chk("make_pop_data", 16'(data), 16'h0);

      // Break F0,1C
      send_byte(8'hF0, 1'b0);
      chk("brk_prefix_no_push", 16'(valid), 16'd0);
      send_byte(8'h1C, 1'b0);
      chk("brk_kp_count", 16'(kp_cnt), 16'd1);
      chk("brk_last_key", 16'(last_key), 16'h1C);
      chk("brk_entry", 16'({valid, ext, brk, data}), 16'({1'b1, 1'b0, 1'b1, 8'h1C}));
      pop();
      chk("brk_pop_valid", 16'(valid), 16'd0);

      // Extended make E0,75
      send_byte(8'hE0, 1'b0);
      send_byte(8'h75, 1'b0);
      chk("ext_make_entry", 16'({valid, ext, brk, data}), 16'({1'b1, 1'b1, 1'b0, 8'h75}));
      chk("ext_make_kp_count", 16'(kp_cnt), 16'd2);
      chk("ext_make_last_key", 16'(last_key), 16'h75);
      pop();

      // Extended break E0,F0,75
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      chk("ext_brk_entry", 16'({valid, ext, brk, data}), 16'({1'b1, 1'b1, 1'b1, 8'h75}));
      chk("ext_brk_kp_count", 16'(kp_cnt), 16'd2);
      pop();
      chk("ext_brk_pop_valid", 16'(valid), 16'd0);

      // Bad parity, then a good 0x29
      send_byte(8'h1C, 1'b1);
      chk("par_ferr_count", 16'(ferr_cnt), 16'd1);
      chk("par_fifo_empty", 16'(valid), 16'd0);
      chk("par_kp_count", 16'(kp_cnt), 16'd2);
      send_byte(8'h29, 1'b0);
      chk("par_next_last_key", 16'(last_key), 16'h29);
      chk("par_next_entry", 16'({valid, ext, brk, data}), 16'({1'b1, 1'b0, 1'b0, 8'h29}));
      pop();

      // Timeout after 5 data bits, then a good 0x29
      send_partial(8'h1C, 5);
      repeat (250) @(negedge clk);
      chk("to_ferr_count", 16'(ferr_cnt), 16'd2);
      chk("to_fifo_empty", 16'(valid), 16'd0);
      send_byte(8'h29, 1'b0);
      chk("to_next_entry", 16'({valid, ext, brk, data}), 16'({1'b1, 1'b0, 1'b0, 8'h29}));
      chk("to_next_kp_count", 16'(kp_cnt), 16'd4);
      pop();

      // Reset mid-frame discards the partial frame
      send_partial(8'h5A, 4);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_outputs", 16'({valid, data, ext, brk, key_pressed, frame_err, overflow}), 16'h0);
      chk("rst_mid_last_key", 16'(last_key), 16'h0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      send_byte(8'h1C, 1'b0);
      chk("rst_next_entry", 16'({valid, ext, brk, data}), 16'({1'b1, 1'b0, 1'b0, 8'h1C}));
      chk("rst_next_last_key", 16'(last_key), 16'h1C);
      pop();

      // Overflow on the fifth make code
      for (int i = 0; i < 5; i++) send_byte(ovf_codes[i], 1'b0);
      chk("ovf_count", 16'(ovf_cnt), 16'd1);
      chk("ovf_last_key", 16'(last_key), 16'h2C);
      chk("ovf_kp_count", 16'(kp_cnt), 16'd10);
      chk("ovf_ferr_count", 16'(ferr_cnt), 16'd2);
      @(negedge clk);
      rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_read_%0d", i), 16'({valid, data}), 16'({1'b1, ovf_codes[i]}));
         @(negedge clk);
      end
      rd = 1'b0;
      chk("ovf_drained_valid", 16'(valid), 16'd0);
      chk("ovf_drained_data", 16'(data), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
